// File: rtl/biriscv_mul_wb_tracker_pkg.sv
// -----------------------------------------------------------------------------
// biriscv_mul_wb_tracker_pkg
// Shared definitions for the multiply writeback tracker:
//   REG_IDX_W         - width of a register index (rd)
//   PC_W              - width of an instruction PC
//   mul_stage_t       - one pipeline stage record {valid, rd, pc}
//   mult_stages_legal - legal-value check for the MULT_STAGES parameter
// -----------------------------------------------------------------------------
package biriscv_mul_wb_tracker_pkg;

    localparam int REG_IDX_W = 5;
    localparam int PC_W      = 32;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [PC_W-1:0]      pc;
    } mul_stage_t;

    // The tracker must mirror the multiplier exactly; only 2 or 3 stages exist.
    function automatic logic mult_stages_legal(input int stages);
        return (stages == 2) || (stages == 3);
    endfunction

endpackage

// File: rtl/biriscv_mul_wb_tracker_stage_reg.sv
// -----------------------------------------------------------------------------
// biriscv_mul_stage_reg
// One {valid, rd, pc} pipeline flop of the multiply tracker.
// Ports:
//   clk_i      in  clock
//   rst_i      in  synchronous active-low reset (clears all fields)
//   en_i       in  advance enable (low while the pipeline is held)
//   clr_i      in  clear valid when not advancing (squash during hold)
//   d_valid_i / d_rd_i / d_pc_i   in   next-stage record
//   q_valid_o / q_rd_o / q_pc_o   out  registered record
// -----------------------------------------------------------------------------
module biriscv_mul_stage_reg
    import biriscv_mul_wb_tracker_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 d_valid_i,
    input  logic [REG_IDX_W-1:0] d_rd_i,
    input  logic [PC_W-1:0]      d_pc_i,
    output logic                 q_valid_o,
    output logic [REG_IDX_W-1:0] q_rd_o,
    output logic [PC_W-1:0]      q_pc_o
);

    logic                 r_valid;
    logic [REG_IDX_W-1:0] r_rd;
    logic [PC_W-1:0]      r_pc;

    // Advancing takes priority over clear: the caller folds any squash into
    // d_valid_i when the stage advances, so clr_i only matters while held.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_rd    <= '0;
            r_pc    <= '0;
        end else if (en_i) begin
            r_valid <= d_valid_i;
            r_rd    <= d_rd_i;
            r_pc    <= d_pc_i;
        end else if (clr_i) begin
            r_valid <= 1'b0;
        end
    end

    assign q_valid_o = r_valid;
    assign q_rd_o    = r_rd;
    assign q_pc_o    = r_pc;

endmodule

// File: rtl/biriscv_mul_wb_tracker.sv
// -----------------------------------------------------------------------------
// biriscv_mul_wb_tracker
// Shadows the fixed-latency multiplier with a {valid, rd, pc} shift register so
// the multiplier's raw result leaves as a qualified writeback request.
// Ports:
//   clk_i, rst_i (sync, active-low)
//   opcode_valid_i, opcode_is_mul_i, opcode_rd_idx_i, opcode_pc_i  issue side
//   hold_i        pipeline hold shared with the multiplier
//   squash_e1_i   kills the entry sitting in E1
//   mul_result_i  multiplier result, passed through on writeback
//   wb_valid_o, wb_rd_idx_o, wb_pc_o, wb_value_o  writeback request
//   pending_mask_o  one bit per in-flight rd (bit 0 always 0)
//   mul_retired_o   count of multiplies leaving the last stage
// -----------------------------------------------------------------------------
module biriscv_mul_wb_tracker
    import biriscv_mul_wb_tracker_pkg::*;
#(
    parameter int MULT_STAGES = 2
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 opcode_valid_i,
    input  logic                 opcode_is_mul_i,
    input  logic [REG_IDX_W-1:0] opcode_rd_idx_i,
    input  logic [PC_W-1:0]      opcode_pc_i,
    input  logic                 hold_i,
    input  logic                 squash_e1_i,
    input  logic [31:0]          mul_result_i,
    output logic                 wb_valid_o,
    output logic [REG_IDX_W-1:0] wb_rd_idx_o,
    output logic [PC_W-1:0]      wb_pc_o,
    output logic [31:0]          wb_value_o,
    output logic [31:0]          pending_mask_o,
    output logic [31:0]          mul_retired_o
);

    generate
        if (!mult_stages_legal(MULT_STAGES)) begin : g_bad_stages
            $error("biriscv_mul_wb_tracker: MULT_STAGES must be 2 or 3");
        end
    endgenerate

    localparam int LAST = MULT_STAGES - 1;

    logic                 w_accept;
    logic                 w_valid [MULT_STAGES];
    logic [REG_IDX_W-1:0] w_rd    [MULT_STAGES];
    logic [PC_W-1:0]      w_pc    [MULT_STAGES];
    logic                 w_last_valid;
    logic [31:0]          w_pending;
    logic [31:0]          r_retired;

    assign w_accept = opcode_valid_i && opcode_is_mul_i && !hold_i;

    genvar gi;
    generate
        for (gi = 0; gi < MULT_STAGES; gi++) begin : g_stage
            logic                 w_d_valid;
            logic [REG_IDX_W-1:0] w_d_rd;
            logic [PC_W-1:0]      w_d_pc;
            logic                 w_clr;

            if (gi == 0) begin : g_e1
                // A non-accepted slot loads a bubble with zeroed fields; an
                // accept overrides a simultaneous squash (flush + refetch).
                assign w_d_valid = w_accept;
                assign w_d_rd    = w_accept ? opcode_rd_idx_i : '0;
                assign w_d_pc    = w_accept ? opcode_pc_i : '0;
                assign w_clr     = squash_e1_i;
            end else if (gi == 1) begin : g_e2
                // An E1 entry squashed this edge must not be promoted.
                assign w_d_valid = w_valid[gi-1] && !squash_e1_i;
                assign w_d_rd    = w_rd[gi-1];
                assign w_d_pc    = w_pc[gi-1];
                assign w_clr     = 1'b0;
            end else begin : g_en
                assign w_d_valid = w_valid[gi-1];
                assign w_d_rd    = w_rd[gi-1];
                assign w_d_pc    = w_pc[gi-1];
                assign w_clr     = 1'b0;
            end

            biriscv_mul_stage_reg u_stage (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .en_i      (!hold_i),
                .clr_i     (w_clr),
                .d_valid_i (w_d_valid),
                .d_rd_i    (w_d_rd),
                .d_pc_i    (w_d_pc),
                .q_valid_o (w_valid[gi]),
                .q_rd_o    (w_rd[gi]),
                .q_pc_o    (w_pc[gi])
            );
        end
    endgenerate

    assign w_last_valid = w_valid[LAST];

    // Scoreboard is built purely from stage registers, so issue-side inputs
    // never reach pending_mask_o combinationally.
    always_comb begin
        w_pending = '0;
        for (int i = 0; i < MULT_STAGES; i++) begin
            if (w_valid[i] && (w_rd[i] != '0)) begin
                w_pending[w_rd[i]] = 1'b1;
            end
        end
    end

    // rd=x0 multiplies still retire, so the count uses valid alone.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_retired <= '0;
        end else if (w_last_valid && !hold_i) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign wb_valid_o     = w_last_valid && (w_rd[LAST] != '0);
    assign wb_rd_idx_o    = w_rd[LAST];
    assign wb_pc_o        = w_pc[LAST];
    assign wb_value_o     = wb_valid_o ? mul_result_i : 32'd0;
    assign pending_mask_o = w_pending;
    assign mul_retired_o  = r_retired;

endmodule

// File: tb/tb_biriscv_mul_wb_tracker.sv
// -----------------------------------------------------------------------------
// tb_biriscv_mul_wb_tracker
// Drives a 2-stage and a 3-stage tracker with the same issue stream. Expected
// writebacks are queued at issue and popped when each DUT writes back; cycle-
// accurate directed checks cover timing, hold, squash, reset and wrap.
// -----------------------------------------------------------------------------
module tb_biriscv_mul_wb_tracker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        opv, ismul, hold, squash;
    logic [4:0]  rd;
    logic [31:0] pc, mres;

    logic        wv2, wv3;
    logic [4:0]  wrd2, wrd3;
    logic [31:0] wpc2, wpc3, wval2, wval3, pm2, pm3, cnt2, cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] pc;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];

    biriscv_mul_wb_tracker #(.MULT_STAGES(2)) u_dut2 (
        .clk_i(clk), .rst_i(rst_n),
        .opcode_valid_i(opv), .opcode_is_mul_i(ismul),
        .opcode_rd_idx_i(rd), .opcode_pc_i(pc),
        .hold_i(hold), .squash_e1_i(squash), .mul_result_i(mres),
        .wb_valid_o(wv2), .wb_rd_idx_o(wrd2), .wb_pc_o(wpc2), .wb_value_o(wval2),
        .pending_mask_o(pm2), .mul_retired_o(cnt2)
    );

    biriscv_mul_wb_tracker #(.MULT_STAGES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n),
        .opcode_valid_i(opv), .opcode_is_mul_i(ismul),
        .opcode_rd_idx_i(rd), .opcode_pc_i(pc),
        .hold_i(hold), .squash_e1_i(squash), .mul_result_i(mres),
        .wb_valid_o(wv3), .wb_rd_idx_o(wrd3), .wb_pc_o(wpc3), .wb_value_o(wval3),
        .pending_mask_o(pm3), .mul_retired_o(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // kill removes the youngest queued entry (the one squashed out of E1)
    // before any new accept is queued.
    task automatic drive(input logic v, input logic m, input logic [4:0] r,
                         input logic [31:0] p, input logic h, input logic s,
                         input logic kill);
        opv = v; ismul = m; rd = r; pc = p; hold = h; squash = s;
        mres = $urandom;
        if (kill) begin
            q2.delete(q2.size() - 1);
            q3.delete(q3.size() - 1);
        end
        if (v && m && !h && (r != 5'd0)) begin
            q2.push_back('{rd: r, pc: p});
            q3.push_back('{rd: r, pc: p});
        end
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a writeback is consumed once, on a non-held cycle.
    always @(negedge clk) begin
        exp_t e;
        if (wv2 && !hold) begin
            chk("m2_wb_expected", 32'(q2.size() != 0), 32'd1);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                $display("wb M2 rd=%0d pc=%08h val=%08h", wrd2, wpc2, wval2);
                chk("m2_rd", 32'(wrd2), 32'(e.rd));
                chk("m2_pc", wpc2, e.pc);
                chk("m2_val", wval2, mres);
            end
        end
        if (!wv2) chk("m2_val_zero", wval2, 32'd0);
        if (wv3 && !hold) begin
            chk("m3_wb_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                e = q3.pop_front();
                $display("wb M3 rd=%0d pc=%08h val=%08h", wrd3, wpc3, wval3);
                chk("m3_rd", 32'(wrd3), 32'(e.rd));
                chk("m3_pc", wpc3, e.pc);
                chk("m3_val", wval3, mres);
            end
        end
        if (!wv3) chk("m3_val_zero", wval3, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        nop();
        repeat (3) next();
        rst_n = 1'b1;

        // ---- reset state
        nop(); mid();
        chk("rst_wv2", 32'(wv2), 0); chk("rst_pm2", pm2, 0); chk("rst_cnt2", cnt2, 0);
        chk("rst_wpc2", wpc2, 0);    chk("rst_wv3", 32'(wv3), 0); chk("rst_cnt3", cnt3, 0);
        next();

        // ---- single multiply
        drive(1, 1, 5'd5, 32'h100, 0, 0, 0); mid(); chk("t1_pm_c10", pm2, 0); next();
        nop(); mid(); chk("t1_wv_c11", 32'(wv2), 0); chk("t1_pm_c11", pm2, 32'h20); next();
        nop(); mid();
        chk("t1_wv_c12", 32'(wv2), 1); chk("t1_rd_c12", 32'(wrd2), 5);
        chk("t1_pc_c12", wpc2, 32'h100); chk("t1_pm_c12", pm2, 32'h20); chk("t1_wv3_c12", 32'(wv3), 0);
        next();
        nop(); mid();
        chk("t1_wv_c13", 32'(wv2), 0); chk("t1_pm_c13", pm2, 0); chk("t1_cnt2", cnt2, 1);
        chk("t1_wv3_c13", 32'(wv3), 1); chk("t1_pm3_c13", pm3, 32'h20);
        next();
        nop(); mid(); chk("t1_cnt3", cnt3, 1); chk("t1_pm3_c14", pm3, 0); next();

        // ---- valid non-multiply is ignored
        drive(1, 0, 5'd6, 32'h180, 0, 0, 0); mid(); next();
        nop(); mid(); chk("nm_pm", pm2, 0); next();
        nop(); mid(); chk("nm_wv", 32'(wv2), 0); next();

        // ---- hold in E1 (plus an issue attempt while held)
        drive(1, 1, 5'd9, 32'h200, 0, 0, 0); mid(); next();
        drive(0, 0, 5'd0, 32'd0, 1, 0, 0); mid(); chk("h_pm_c11", pm2, 32'h200); chk("h_wv_c11", 32'(wv2), 0); next();
        drive(1, 1, 5'd11, 32'h300, 1, 0, 0); mid(); chk("h_pm_c12", pm2, 32'h200); next();
        drive(0, 0, 5'd0, 32'd0, 1, 0, 0); mid(); chk("h_pm_c13", pm2, 32'h200); chk("h_wv_c13", 32'(wv2), 0); next();
        nop(); mid(); chk("h_wv_c14", 32'(wv2), 0); chk("h_pm_c14", pm2, 32'h200); next();
        nop(); mid(); chk("h_wv_c15", 32'(wv2), 1); chk("h_rd_c15", 32'(wrd2), 9); chk("h_wv3_c15", 32'(wv3), 0); next();
        nop(); mid(); chk("h_wv_c16", 32'(wv2), 0); chk("h_pm_c16", pm2, 0); chk("h_cnt2", cnt2, 2); chk("h_wv3_c16", 32'(wv3), 1); next();
        nop(); mid(); chk("h_cnt3", cnt3, 2); next();

        // ---- hold while the last stage is writing back
        drive(1, 1, 5'd13, 32'h400, 0, 0, 0); mid(); next();
        nop(); mid(); next();
        drive(0, 0, 5'd0, 32'd0, 1, 0, 0); mid();
        chk("hw_wv_c2", 32'(wv2), 1); chk("hw_rd_c2", 32'(wrd2), 13); chk("hw_pc_c2", wpc2, 32'h400); chk("hw_cnt_c2", cnt2, 2);
        next();
        drive(0, 0, 5'd0, 32'd0, 1, 0, 0); mid();
        chk("hw_wv_c3", 32'(wv2), 1); chk("hw_rd_c3", 32'(wrd2), 13); chk("hw_cnt_c3", cnt2, 2);
        next();
        nop(); mid(); chk("hw_wv_c4", 32'(wv2), 1); next();
        nop(); mid(); chk("hw_wv_c5", 32'(wv2), 0); chk("hw_cnt_c5", cnt2, 3); chk("hw_wv3_c5", 32'(wv3), 1); next();
        nop(); mid(); chk("hw_cnt3", cnt3, 3); next();

        // ---- squash
        drive(1, 1, 5'd7, 32'h500, 0, 0, 0); mid(); next();
        drive(0, 0, 5'd0, 32'd0, 0, 1, 1); mid(); chk("s_pm_c11", pm2, 32'h80); next();
        nop(); mid(); chk("s_pm_c12", pm2, 0); chk("s_wv_c12", 32'(wv2), 0); chk("s_pm3_c12", pm3, 0); next();
        nop(); mid(); chk("s_wv_c13", 32'(wv2), 0); chk("s_wv3_c13", 32'(wv3), 0); next();
        nop(); mid(); chk("s_cnt2", cnt2, 3); chk("s_cnt3", cnt3, 3); next();

        // ---- squash with simultaneous accept
        drive(1, 1, 5'd7, 32'h600, 0, 0, 0); mid(); next();
        drive(1, 1, 5'd8, 32'h700, 0, 1, 1); mid(); chk("sa_pm_c11", pm2, 32'h80); next();
        nop(); mid(); chk("sa_pm_c12", pm2, 32'h100); chk("sa_wv_c12", 32'(wv2), 0); next();
        nop(); mid(); chk("sa_wv_c13", 32'(wv2), 1); chk("sa_rd_c13", 32'(wrd2), 8); chk("sa_pm_c13", pm2, 32'h100); next();
        nop(); mid(); chk("sa_wv_c14", 32'(wv2), 0); chk("sa_cnt2", cnt2, 4); chk("sa_wv3_c14", 32'(wv3), 1); next();
        nop(); mid(); chk("sa_cnt3", cnt3, 4); next();

        // ---- squash while held
        drive(1, 1, 5'd10, 32'h800, 0, 0, 0); mid(); next();
        drive(0, 0, 5'd0, 32'd0, 1, 1, 1); mid(); chk("sh_pm_c1", pm2, 32'h400); next();
        nop(); mid(); chk("sh_pm_c2", pm2, 0); next();
        nop(); mid(); chk("sh_wv_c3", 32'(wv2), 0); next();
        nop(); mid(); chk("sh_cnt2", cnt2, 4); chk("sh_cnt3", cnt3, 4); next();

        // ---- back-to-back with rd=x0
        drive(1, 1, 5'd0, 32'h900, 0, 0, 0); mid(); next();
        drive(1, 1, 5'd3, 32'h904, 0, 0, 0); mid(); chk("bb_pm_c11", pm2, 0); next();
        drive(1, 1, 5'd3, 32'h908, 0, 0, 0); mid(); chk("bb_wv_c12", 32'(wv2), 0); chk("bb_pm_c12", pm2, 32'h8); next();
        nop(); mid(); chk("bb_wv_c13", 32'(wv2), 1); chk("bb_pc_c13", wpc2, 32'h904); chk("bb_pm_c13", pm2, 32'h8); next();
        nop(); mid(); chk("bb_wv_c14", 32'(wv2), 1); chk("bb_pc_c14", wpc2, 32'h908); chk("bb_pm_c14", pm2, 32'h8); next();
        nop(); mid(); chk("bb_wv_c15", 32'(wv2), 0); chk("bb_pm_c15", pm2, 0); chk("bb_cnt2", cnt2, 7); next();
        nop(); mid(); chk("bb_cnt3", cnt3, 7); next();

        // ---- reset mid-flight
        drive(1, 1, 5'd12, 32'hA00, 0, 0, 0); mid(); next();
        nop(); rst_n = 1'b0; q2.delete(); q3.delete();
        mid(); chk("rm_pm_c11", pm2, 32'h1000); next();
        rst_n = 1'b1; nop(); mid();
        chk("rm_wv2", 32'(wv2), 0); chk("rm_pm2", pm2, 0); chk("rm_cnt2", cnt2, 0);
        chk("rm_rd2", 32'(wrd2), 0); chk("rm_pc2", wpc2, 0); chk("rm_val2", wval2, 0);
        chk("rm_pm3", pm3, 0); chk("rm_cnt3", cnt3, 0); chk("rm_pc3", wpc3, 0);
        next();
        nop(); mid(); chk("rm_wv2_c13", 32'(wv2), 0); chk("rm_wv3_c13", 32'(wv3), 0); next();
        nop(); mid(); chk("rm_wv3_c14", 32'(wv3), 0); chk("rm_cnt2_c14", cnt2, 0); next();

        // ---- counter wrap
        nop();
        force u_dut2.r_retired = 32'hFFFF_FFFF;
        force u_dut3.r_retired = 32'hFFFF_FFFF;
        mid(); chk("w_forced2", cnt2, 32'hFFFF_FFFF);
        release u_dut2.r_retired;
        release u_dut3.r_retired;
        next();
        drive(1, 1, 5'd14, 32'hB00, 0, 0, 0); mid(); chk("w_pre2", cnt2, 32'hFFFF_FFFF); chk("w_pre3", cnt3, 32'hFFFF_FFFF); next();
        nop(); mid(); next();
        nop(); mid(); chk("w_wv_c2", 32'(wv2), 1); next();
        nop(); mid(); chk("w_cnt2", cnt2, 0); next();
        nop(); mid(); chk("w_cnt3", cnt3, 0); next();

        nop(); mid();
        chk("q2_drained", 32'(q2.size()), 0);
        chk("q3_drained", 32'(q3.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/biriscv_mul_wb_tracker.md
# biriscv_mul_wb_tracker

Tracks multiply instructions alongside the fixed-latency multiplier and turns its raw result stream into a qualified writeback request. Sits beside and directly downstream of the multiplier: it captures issue-side control (valid, rd, pc) in parallel with the multiplier's operand register. It presents `{valid, rd, pc, value}` to the register-file writeback mux at the cycle the multiplier's result appears. It also exports a pending-rd scoreboard to the issue stage for RAW stalls, and a retired-multiply counter.

## Interface
- `MULT_STAGES`, default 2 — multiplier latency in cycles; legal values are 2 or 3 only. It must match the multiplier instance.
- `clk_i`  in  1 — clock.
- `rst_i`  in  1 — synchronous, active-low reset; one clock domain.
- `opcode_valid_i`  in  1 — an instruction is presented at issue this cycle.
- `opcode_is_mul_i`  in  1 — decoded MUL/MULH/MULHSU/MULHU.
- `opcode_rd_idx_i`  in  5 — destination register.
- `opcode_pc_i`  in  32 — instruction PC.
- `hold_i`  in  1 — pipeline hold; the same signal that drives the multiplier.
- `squash_e1_i`  in  1 — kills the instruction in E1 (branch or exception flush).
- `mul_result_i`  in  32 — the multiplier's `writeback_value_o`.
- `wb_valid_o`  out  1 — writeback request.
- `wb_rd_idx_o`  out  5 — writeback rd.
- `wb_pc_o`  out  32 — writeback PC.
- `wb_value_o`  out  32 — writeback data.
- `pending_mask_o`  out  32 — bit n set when rd=n is in flight.
- `mul_retired_o`  out  32 — count of completed multiply writebacks.

## Operation
- **Accept.** An instruction is accepted when `opcode_valid_i && opcode_is_mul_i && !hold_i`. On accept, E1 loads `{1, rd, pc}`. If not accepted and `hold_i` is low, E1 loads valid=0; rd and pc are don't-care but are driven to 0.
- **Shift.** Stages E1 → E2 → (E3 when `MULT_STAGES==3`) form a shift register. Each stage holds `{valid, rd[4:0], pc[31:0]}`. The chain advances only when `!hold_i`.
- **Hold.** `hold_i` freezes all stages, the counter and the scoreboard contributions.
- **Squash.** `squash_e1_i` clears E1.valid at the clock edge, regardless of `hold_i`; squash has priority over hold. Stages past E1 are committed and are never squashed.
- **Squash and accept together.** If `squash_e1_i` and an accept occur in the same cycle, the new instruction loads into E1 and the old E1 entry is dropped. This is the flush-plus-refetch case; the old entry must not advance into E2.
- **Last stage.** The last stage is E2 or E3, selected by `MULT_STAGES`.
  - `wb_valid_o = last.valid && (last.rd != 0)`.
  - `wb_rd_idx_o = last.rd`, `wb_pc_o = last.pc`.
  - `wb_value_o = mul_result_i`, combinational passthrough.
  - When `wb_valid_o` is 0, `wb_value_o` is forced to 0.
- **Scoreboard.** `pending_mask_o` is the OR of one-hot(rd) over every valid stage with rd≠0, including the last stage. Bit 0 is always 0. Several stages may target the same rd; the bit stays set until all of them drain.
- **Counter.** `mul_retired_o` increments by 1 on each cycle with `last.valid && !hold_i`; rd=0 instructions are counted. It wraps from 0xFFFFFFFF to 0.
- **Reset.** On reset, all stage valids, rd fields, pc fields and the counter are 0. All outputs therefore read 0 in the cycle after reset is sampled low. Reset asserted mid-flight discards in-flight entries with no writeback.

## Timing
- Issue at cycle N (accepted) gives E1 valid in N+1.
  - `MULT_STAGES==2`: `wb_valid_o` in N+2.
  - `MULT_STAGES==3`: `wb_valid_o` in N+3.
- This aligns exactly with the multiplier's result register.
- Each hold cycle adds exactly one cycle of latency. The outputs stay stable, and `wb_valid_o` remains asserted for the whole held period. The writeback consumer must gate its write with `!hold_i`.
- Throughput is one multiply per cycle; back-to-back accepts produce back-to-back `wb_valid_o`.
- A pending bit sets in the cycle after accept and clears in the cycle after the last stage advances.
- Combinational paths are limited to last-stage register → outputs and `mul_result_i` → `wb_value_o`. There is no path from input to `pending_mask_o`.

## Structure
- Shared package (`biriscv_defs` includes): the stage-record field widths (REG_IDX_W=5, PC_W=32) and the `MULT_STAGES` legal-value check.
- One sub-module is natural: `biriscv_mul_stage_reg`, a single `{valid, rd, pc}` flop with hold, squash and reset inputs. Instantiate it 2 or 3 times via generate on `MULT_STAGES`.
- The scoreboard OR and the counter live in the top level.

## Test plan
- **Single multiply.** `MULT_STAGES=2`, MUL rd=5 pc=0x100 at cycle 10 → `wb_valid_o`=1 at cycle 12 only, with rd=5, pc=0x100, value = `mul_result_i`. `pending_mask_o`=0x20 during cycles 11–12 and 0 at cycle 13. `mul_retired_o`=1.
- **Hold.** Accept at cycle 10, then `hold_i`=1 for cycles 11–13 → `wb_valid_o` asserted at cycles 15 through 15 only, with all outputs frozen throughout the hold. Repeat with `MULT_STAGES=3` → writeback at cycle 16.
- **Squash.** Accept rd=7 at cycle 10, `squash_e1_i`=1 at cycle 11 → no writeback, `pending_mask_o` bit 7 cleared at cycle 12, counter unchanged. Repeat with a simultaneous accept of rd=8 → only rd=8 writes back, at cycle 13.
- **rd=x0 and back-to-back.** Back-to-back accepts rd=0, 3, 3 at cycles 10–12 → `wb_valid_o` pattern 0,1,1 at cycles 12–14. `pending_mask_o` bit 3 stays set from cycle 12 to 14 and clears at cycle 15. Counter +3.
- **Reset mid-flight.** Accept at cycle 10, `rst_i`=0 sampled at cycle 11 → no writeback, all outputs 0 at cycle 12.
- **Counter wrap.** Preload the counter via 2^32−1 accepts (or force), then one more → `mul_retired_o`=0.
